lfsr_engine: RTL and testbench

//  Parametrised Fibonacci LFSR with command-driven sequencing: free-run, N-step burst, single step, hold.

---
 rtl/lfsr_engine.sv | 141 ++++++++++++++
 tb/tb_lfsr_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_engine.sv
// lfsr_engine: Fibonacci LFSR sequenced by HOLD/RUN/BURST/SINGLE commands.
// Optional escape from the all-zero state: define LFSR_LOCKUP_RECOVER_EN.
module lfsr_engine #(
  parameter int               WIDTH      = 20,
  parameter logic [WIDTH-1:0] TAPS       = 20'h08881,
  parameter int               STEPS      = 1,
  parameter int               CNT_W      = 16,
  parameter logic [WIDTH-1:0] RESET_SEED = 20'h00001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] lfsr,
  output logic             busy,
  output logic             done,
  output logic             lockup
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    BURST
  } state_t;

  localparam logic [1:0] M_HOLD   = 2'b00;
  localparam logic [1:0] M_RUN    = 2'b01;
  localparam logic [1:0] M_BURST  = 2'b10;
  localparam logic [1:0] M_SINGLE = 2'b11;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             accept;
  logic             adv_en;
  logic [WIDTH-1:0] seed_v;
  logic [WIDTH-1:0] adv;
  logic [WIDTH-1:0] lfsr_nxt;

  function automatic logic [WIDTH-1:0] advance(
    input logic [WIDTH-1:0] s
  );
    logic [WIDTH-1:0] r;
    r = s;
    for (int i = 0; i < STEPS; i++) begin
      r = {^(r & TAPS), r[WIDTH-1:1]};
    end
`ifdef LFSR_LOCKUP_RECOVER_EN
    if (s == '0 || r == '0) r = RESET_SEED;
`endif
    return r;
  endfunction

`ifdef LFSR_LOCKUP_RECOVER_EN
  assign seed_v = (seed == '0) ? RESET_SEED : seed;
`else
  assign seed_v = seed;
`endif

  assign cmd_ready = (state != BURST);
  assign accept    = cmd_valid && cmd_ready && !load;
  assign adv       = advance(lfsr);

  always_comb begin
    adv_en = 1'b0;
    if (accept) begin
      adv_en = (cmd_mode == M_RUN) || (cmd_mode == M_SINGLE) ||
               (cmd_mode == M_BURST && cmd_count != '0);
    end else if (!load) begin
      adv_en = (state != IDLE);
    end
  end

  assign lfsr_nxt = load ? seed_v : (adv_en ? adv : lfsr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr      <= RESET_SEED;
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
    end else begin
      lfsr <= lfsr_nxt;
      done <= 1'b0;
      if (load) begin
        state     <= IDLE;
        busy      <= 1'b0;
        remaining <= '0;
      end else if (accept) begin
        unique case (cmd_mode)
          M_RUN: begin
            state <= RUN;
            busy  <= 1'b1;
          end
          M_SINGLE: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          M_BURST: begin
            // N=0 and N=1 both finish at the accepting edge
            if (cmd_count <= CNT_W'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= BURST;
              busy      <= 1'b1;
              remaining <= cmd_count - CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end else if (state == BURST) begin
        remaining <= remaining - CNT_W'(1);
        if (remaining == CNT_W'(1)) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

`ifdef LFSR_LOCKUP_RECOVER_EN
  assign lockup = 1'b0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lockup <= 1'b0;
    else        lockup <= (lfsr_nxt == '0);
  end
`endif

endmodule

// File: tb/tb_lfsr_engine.sv
// tb_lfsr_engine: vector table plus scoreboard for lfsr_engine.
// Drives at negedge, samples 1ns after posedge; STEPS=4 via second instance.
module tb_lfsr_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [19:0] seed = '0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_mode = 2'b00;
  logic [15:0] cmd_count = '0;

  logic        rdy, busy, done, lockup;
  logic [19:0] lfsr;
  logic        rdy4, busy4, done4, lockup4;
  logic [19:0] lfsr4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_engine dut (
    .clk(clk), .rst_n(rst_n), .load(load), .seed(seed),
    .cmd_valid(cmd_valid), .cmd_ready(rdy), .cmd_mode(cmd_mode),
    .cmd_count(cmd_count), .lfsr(lfsr), .busy(busy), .done(done),
    .lockup(lockup)
  );

  lfsr_engine #(.STEPS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .load(load), .seed(seed),
    .cmd_valid(cmd_valid), .cmd_ready(rdy4), .cmd_mode(cmd_mode),
    .cmd_count(cmd_count), .lfsr(lfsr4), .busy(busy4), .done(done4),
    .lockup(lockup4)
  );

  typedef struct {
    logic        ld;
    logic [19:0] sd;
    logic        vld;
    logic [1:0]  md;
    logic [15:0] cnt;
    logic [19:0] e_lfsr;
    logic        e_done;
    logic        e_busy;
    logic        e_rdy;
  } vec_t;

  typedef struct {
    string       tag;
    logic [19:0] lfsr;
    logic        done;
    logic        busy;
    logic        rdy;
    logic        lockup;
    logic        chk4;
    logic [19:0] lfsr4;
    logic        done4;
  } exp_t;

  exp_t sb[$];

  function automatic logic [19:0] m_adv(logic [19:0] s, int n);
    logic [19:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = {^(r & 20'h08881), r[19:1]};
`ifdef LFSR_LOCKUP_RECOVER_EN
    if (s == 20'h0 || r == 20'h0) r = 20'h00001;
`endif
    return r;
  endfunction

  function automatic logic m_lock(logic [19:0] s);
`ifdef LFSR_LOCKUP_RECOVER_EN
    return 1'b0;
`else
    return (s == 20'h0);
`endif
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      cmp("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    cmp({e.tag, ".lfsr"}, 32'(lfsr), 32'(e.lfsr));
    cmp({e.tag, ".done"}, 32'(done), 32'(e.done));
    cmp({e.tag, ".busy"}, 32'(busy), 32'(e.busy));
    cmp({e.tag, ".rdy"}, 32'(rdy), 32'(e.rdy));
    cmp({e.tag, ".lockup"}, 32'(lockup), 32'(e.lockup));
    if (e.chk4) begin
      cmp({e.tag, ".lfsr4"}, 32'(lfsr4), 32'(e.lfsr4));
      cmp({e.tag, ".done4"}, 32'(done4), 32'(e.done4));
    end
  endtask

  task automatic cyc(input logic ld, input logic [19:0] sd,
                     input logic vld, input logic [1:0] md,
                     input logic [15:0] cnt, input exp_t e);
    @(negedge clk);
    load      = ld;
    seed      = sd;
    cmd_valid = vld;
    cmd_mode  = md;
    cmd_count = cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  vec_t        tbl[23];
  exp_t        e;
  logic [19:0] m1, m4, z;

  initial begin
    tbl[0]  = '{1, 20'h00001, 0, 2'd0, 16'd0, 20'h00001, 0, 0, 1};
    tbl[1]  = '{0, 20'h0,     1, 2'd3, 16'd0, 20'h80000, 1, 0, 1};
    tbl[2]  = '{0, 20'h0,     1, 2'd3, 16'd0, 20'h40000, 1, 0, 1};
    tbl[3]  = '{0, 20'h0,     0, 2'd0, 16'd0, 20'h40000, 0, 0, 1};
    tbl[4]  = '{1, 20'h00001, 0, 2'd0, 16'd0, 20'h00001, 0, 0, 1};
    tbl[5]  = '{0, 20'h0,     1, 2'd2, 16'd3, 20'h80000, 0, 1, 0};
    tbl[6]  = '{0, 20'h0,     1, 2'd3, 16'd0, 20'h40000, 0, 1, 0};
    tbl[7]  = '{0, 20'h0,     0, 2'd0, 16'd0, 20'h20000, 1, 0, 1};
    tbl[8]  = '{0, 20'h0,     0, 2'd0, 16'd0, 20'h20000, 0, 0, 1};
    tbl[9]  = '{0, 20'h0,     1, 2'd2, 16'd0, 20'h20000, 1, 0, 1};
    tbl[10] = '{0, 20'h0,     0, 2'd0, 16'd0, 20'h20000, 0, 0, 1};
    tbl[11] = '{0, 20'h0,     1, 2'd2, 16'd5, 20'h10000, 0, 1, 0};
    tbl[12] = '{1, 20'h12345, 1, 2'd1, 16'd0, 20'h12345, 0, 0, 1};
    tbl[13] = '{0, 20'h0,     0, 2'd0, 16'd0, 20'h12345, 0, 0, 1};
    tbl[14] = '{0, 20'h0,     0, 2'd0, 16'd0, 20'h12345, 0, 0, 1};
    tbl[15] = '{0, 20'h0,     0, 2'd0, 16'd0, 20'h12345, 0, 0, 1};
    tbl[16] = '{1, 20'h00001, 0, 2'd0, 16'd0, 20'h00001, 0, 0, 1};
    tbl[17] = '{0, 20'h0,     1, 2'd1, 16'd0, 20'h80000, 0, 1, 1};
    tbl[18] = '{0, 20'h0,     1, 2'd3, 16'd7, 20'h40000, 1, 0, 1};
    tbl[19] = '{0, 20'h0,     1, 2'd1, 16'd0, 20'h20000, 0, 1, 1};
    tbl[20] = '{0, 20'h0,     1, 2'd0, 16'd0, 20'h20000, 0, 0, 1};
    tbl[21] = '{0, 20'h0,     1, 2'd2, 16'd1, 20'h10000, 1, 0, 1};
    tbl[22] = '{0, 20'h0,     0, 2'd0, 16'd0, 20'h10000, 0, 0, 1};

    #12;
    cmp("rst.lfsr", 32'(lfsr), 32'h00001);
    cmp("rst.busy", 32'(busy), 32'd0);
    cmp("rst.done", 32'(done), 32'd0);
    cmp("rst.rdy", 32'(rdy), 32'd1);
    cmp("rst.lockup", 32'(lockup), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      e = '{$sformatf("vec%0d", i), tbl[i].e_lfsr, tbl[i].e_done,
            tbl[i].e_busy, tbl[i].e_rdy, 1'b0, 1'b0, 20'h0, 1'b0};
      cyc(tbl[i].ld, tbl[i].sd, tbl[i].vld, tbl[i].md, tbl[i].cnt, e);
    end

    e = '{"s4.load", 20'h00001, 0, 0, 1, 0, 1, 20'h00001, 0};
    cyc(1, 20'h00001, 0, 2'd0, 16'd0, e);
    e = '{"s4.single", 20'h80000, 1, 0, 1, 0, 1, 20'h10000, 1};
    cyc(0, 20'h0, 1, 2'd3, 16'd0, e);

    m1 = 20'h0ACE1;
    m4 = 20'h0ACE1;
    e = '{"run.load", m1, 0, 0, 1, 0, 1, m4, 0};
    cyc(1, 20'h0ACE1, 0, 2'd0, 16'd0, e);
    for (int i = 0; i < 1000; i++) begin
      m1 = m_adv(m1, 1);
      m4 = m_adv(m4, 4);
      e = '{$sformatf("run%0d", i), m1, 0, 1, 1, m_lock(m1), 1, m4, 0};
      cyc(0, 20'h0, (i == 0), 2'd1, 16'd0, e);
    end

    z = m_adv(20'h0, 0);
`ifdef LFSR_LOCKUP_RECOVER_EN
    z = 20'h00001;
`endif
    m1 = z;
    m4 = z;
    e = '{"zero.load", m1, 0, 0, 1, m_lock(m1), 1, m4, 0};
    cyc(1, 20'h0, 0, 2'd0, 16'd0, e);
    for (int i = 0; i < 3; i++) begin
      m1 = m_adv(m1, 1);
      m4 = m_adv(m4, 4);
      e = '{$sformatf("zero.run%0d", i), m1, 0, 1, 1, m_lock(m1),
            1, m4, 0};
      cyc(0, 20'h0, (i == 0), 2'd1, 16'd0, e);
    end
    e = '{"zero.clear", 20'h00003, 0, 0, 1, 0, 1, 20'h00003, 0};
    cyc(1, 20'h00003, 0, 2'd0, 16'd0, e);

    e = '{"arst.pre", 20'h80001, 0, 1, 1, 0, 0, 20'h0, 0};
    cyc(0, 20'h0, 1, 2'd1, 16'd0, e);
    @(negedge clk);
    cmd_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    cmp("arst.lfsr", 32'(lfsr), 32'h00001);
    cmp("arst.busy", 32'(busy), 32'd0);
    cmp("arst.rdy", 32'(rdy), 32'd1);
    #10;
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
